// File: rtl/uart_loader.sv
// uart_loader: parses framed program-load packets from the UART receiver's
// byte stream and writes the payload into CPU memory. The CPU is held for the
// duration of each frame, and each frame ends in a done or err pulse.
// Frame: A5 | ADDR | LEN (0 = 256) | LEN payload bytes | CHK
// CHK = (ADDR + LEN + sum of payload) mod 256.
// Optional build macro UART_LOADER_ACK_EN adds tx_start/tx_byte (ACK 0x06 / NAK 0x15).
//
// state  | meaning
// S_IDLE | waiting for SYNC 0xA5, any other byte ignored
// S_ADDR | expecting the start-address byte
// S_LEN  | expecting the payload length byte
// S_DATA | receiving payload, one memory write per byte
// S_CHK  | expecting the checksum byte
module uart_loader #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
`ifdef UART_LOADER_ACK_EN
    output logic              tx_start,
    output logic [7:0]        tx_byte,
`endif
    output logic              busy
);

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Reloaded to N-1 on a byte; expiry is seen on the N-th edge after that byte.
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base, base_next;
    logic [8:0]        count, count_next;
    logic [8:0]        idx, idx_next;
    logic [7:0]        sum, sum_next;
    logic [TMO_W-1:0]  tmo, tmo_next;
    logic              we_next, done_next, err_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        wdata_next;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state;
        base_next  = base;
        count_next = count;
        idx_next   = idx;
        sum_next   = sum;
        tmo_next   = tmo;
        we_next    = 1'b0;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        done_next  = 1'b0;
        err_next   = 1'b0;

        if (rx_valid) begin
            tmo_next = TMO_RELOAD;
        end else if (state != S_IDLE && tmo != '0) begin
            tmo_next = tmo - TMO_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (rx_valid) begin
                    base_next  = ADDR_W'(rx_data);
                    sum_next   = rx_data;
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    count_next = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    sum_next   = sum + rx_data;
                    idx_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    sum_next   = sum + rx_data;
                    we_next    = 1'b1;
                    addr_next  = base + ADDR_W'(idx);
                    wdata_next = rx_data;
                    idx_next   = idx + 9'd1;
                    if (idx + 9'd1 == count) state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == sum) done_next = 1'b1;
                    else                err_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if (state != S_IDLE && !rx_valid && tmo == '0) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
        end
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base      <= '0;
            count     <= '0;
            idx       <= '0;
            sum       <= '0;
            tmo       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_LOADER_ACK_EN
            tx_start  <= 1'b0;
            tx_byte   <= '0;
`endif
        end else begin
            state     <= state_next;
            base      <= base_next;
            count     <= count_next;
            idx       <= idx_next;
            sum       <= sum_next;
            tmo       <= tmo_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            cpu_hold  <= (state_next != S_IDLE);
            load_done <= done_next;
            load_err  <= err_next;
            busy      <= (state_next != S_IDLE);
`ifdef UART_LOADER_ACK_EN
            tx_start  <= done_next | err_next;
            if (done_next)     tx_byte <= 8'h06;
            else if (err_next) tx_byte <= 8'h15;
`endif
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with TIMEOUT_CYCLES=100.
// Table of per-byte vectors for ordinary frames, plus hand sequences for
// LEN=0, timeout, back-to-back strobes and reset mid-frame.
module tb_uart_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic       busy;
`ifdef UART_LOADER_ACK_EN
    logic       tx_start;
    logic [7:0] tx_byte;
`endif

    int checks = 0;
    int failures = 0;
    int we_count = 0;
    int done_count = 0;
    int err_count = 0;
    logic [7:0] mem_model [0:255];

    uart_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err),
`ifdef UART_LOADER_ACK_EN
        .tx_start(tx_start),
        .tx_byte(tx_byte),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory image and pulse counters fed by the DUT's outputs.
    always @(posedge clk) begin
        if (mem_we) begin
            mem_model[mem_addr] <= mem_wdata;
            we_count <= we_count + 1;
        end
        if (load_done) done_count <= done_count + 1;
        if (load_err)  err_count  <= err_count + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       hold;
        logic       done;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] d, input logic we, input logic [7:0] a,
                               input logic [7:0] w, input logic h, input logic dn,
                               input logic er);
        vec_t r;
        r.data = d; r.we = we; r.addr = a; r.wdata = w; r.hold = h; r.done = dn; r.err = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One strobe; returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int we0, dn0, er0, got;

        // Noise in IDLE
        tbl.push_back(v(8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(8'hFF, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(8'h5A, 0, 8'h00, 8'h00, 0, 0, 0));
        // Good frame
        tbl.push_back(v(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h10, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h03, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h11, 1, 8'h10, 8'h11, 1, 0, 0));
        tbl.push_back(v(8'h22, 1, 8'h11, 8'h22, 1, 0, 0));
        tbl.push_back(v(8'h33, 1, 8'h12, 8'h33, 1, 0, 0));
        tbl.push_back(v(8'h79, 0, 8'h00, 8'h00, 0, 1, 0));
        // Bad checksum
        tbl.push_back(v(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h10, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h03, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h11, 1, 8'h10, 8'h11, 1, 0, 0));
        tbl.push_back(v(8'h22, 1, 8'h11, 8'h22, 1, 0, 0));
        tbl.push_back(v(8'h33, 1, 8'h12, 8'h33, 1, 0, 0));
        tbl.push_back(v(8'h78, 0, 8'h00, 8'h00, 0, 0, 1));
        // Address wrap
        tbl.push_back(v(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'hFE, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h03, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'hAA, 1, 8'hFE, 8'hAA, 1, 0, 0));
        tbl.push_back(v(8'hBB, 1, 8'hFF, 8'hBB, 1, 0, 0));
        tbl.push_back(v(8'hCC, 1, 8'h00, 8'hCC, 1, 0, 0));
        tbl.push_back(v(8'h32, 0, 8'h00, 8'h00, 0, 1, 0));
        // 0xA5 as payload is plain data
        tbl.push_back(v(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h40, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'h01, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(8'hA5, 1, 8'h40, 8'hA5, 1, 0, 0));
        tbl.push_back(v(8'hE6, 0, 8'h00, 8'h00, 0, 1, 0));

        // Reset state
        idle(3);
        check("rst_we", mem_we, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].data);
            check($sformatf("v%0d_we", i), mem_we, tbl[i].we);
            if (tbl[i].we) begin
                check($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
                check($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wdata);
            end
            check($sformatf("v%0d_hold", i), cpu_hold, tbl[i].hold);
            check($sformatf("v%0d_busy", i), busy, tbl[i].hold);
            check($sformatf("v%0d_done", i), load_done, tbl[i].done);
            check($sformatf("v%0d_err", i), load_err, tbl[i].err);
`ifdef UART_LOADER_ACK_EN
            check($sformatf("v%0d_tx_start", i), tx_start, tbl[i].done | tbl[i].err);
            if (tbl[i].done) check($sformatf("v%0d_tx_byte", i), tx_byte, 8'h06);
            if (tbl[i].err)  check($sformatf("v%0d_tx_byte", i), tx_byte, 8'h15);
`endif
            idle(1);
            check($sformatf("v%0d_we_pulse", i), mem_we, 0);
            check($sformatf("v%0d_done_pulse", i), load_done, 0);
            check($sformatf("v%0d_err_pulse", i), load_err, 0);
        end
        check("mem_10", mem_model[8'h10], 8'h11);
        check("mem_ff", mem_model[8'hFF], 8'hBB);
        check("mem_00", mem_model[8'h00], 8'hCC);

        // LEN=0 means 256 payload bytes
        we0 = we_count; dn0 = done_count;
        send(8'hA5); idle(1);
        send(8'h00); idle(1);
        send(8'h00); idle(1);
        for (int i = 0; i < 256; i++) begin
            send(8'h01);
            if (i == 255) begin
                check("len0_last_addr", mem_addr, 8'hFF);
                check("len0_hold", cpu_hold, 1);
            end
            idle(1);
        end
        send(8'h00);
        check("len0_done", load_done, 1);
        check("len0_hold_drop", cpu_hold, 0);
        idle(2);
        check("len0_writes", we_count - we0, 256);
        check("len0_done_cnt", done_count - dn0, 1);

        // Timeout: err exactly 100 edges after the ADDR strobe
        send(8'hA5); idle(1);
        send(8'h20);
        got = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (load_err) begin
                got = k;
                break;
            end
        end
        check("tmo_cycles", got, 100);
        check("tmo_busy", busy, 0);
        check("tmo_hold", cpu_hold, 0);
        idle(1);
        check("tmo_err_pulse", load_err, 0);

        // Back-to-back strobes: A5 50 02 07 08 61
        we0 = we_count; dn0 = done_count; er0 = err_count;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = 8'hA5; @(negedge clk);
        rx_data = 8'h50; @(negedge clk);
        rx_data = 8'h02; @(negedge clk);
        rx_data = 8'h07; @(negedge clk);
        rx_data = 8'h08; @(negedge clk);
        rx_data = 8'h61; @(negedge clk);
        rx_valid = 1'b0;
        idle(3);
        check("b2b_writes", we_count - we0, 2);
        check("b2b_done", done_count - dn0, 1);
        check("b2b_err", err_count - er0, 0);
        check("b2b_mem50", mem_model[8'h50], 8'h07);
        check("b2b_mem51", mem_model[8'h51], 8'h08);

        // Reset mid-DATA aborts silently; earlier writes stand
        we0 = we_count; dn0 = done_count; er0 = err_count;
        send(8'hA5); idle(1);
        send(8'h30); idle(1);
        send(8'h05); idle(1);
        send(8'h01); idle(1);
        send(8'h02);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_err", load_err, 0);
`ifdef UART_LOADER_ACK_EN
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_byte", tx_byte, 0);
`endif
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        send(8'h03);
        check("post_rst_busy", busy, 0);
        check("post_rst_we", mem_we, 0);
        idle(2);
        check("mid_rst_writes", we_count - we0, 2);
        check("mid_rst_mem31", mem_model[8'h31], 8'h02);
        check("mid_rst_no_done", done_count - dn0, 0);
        check("mid_rst_no_err", err_count - er0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
